// File: rtl/layer_stream_serializer_pkg.sv
// Shared types and helpers for the inter-layer vector serializer.
// Imported by the serializer top and its ping-pong buffer.
package layer_stream_serializer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_stream_serializer_pingpong_buf.sv
// Two-entry vector buffer with write/read pointers and occupancy.
// Push and pop may occur in the same cycle; the data array is never reset.
module vector_pingpong_buf
    import layer_stream_serializer_pkg::*;
#(
    parameter int VEC_W = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [VEC_W-1:0] wr_vec,
    output logic             full,
    output logic             empty,
    output logic [VEC_W-1:0] rd_vec
);

    logic [VEC_W-1:0] mem_q [2];
    logic             wp_q, wp_d;
    logic             rp_q, rp_d;
    logic [1:0]       occ_q, occ_d;

    always_comb begin
        wp_d  = wp_q ^ push;
        rp_d  = rp_q ^ pop;
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= wr_vec;
        end
    end

    assign full   = (occ_q == 2'd2);
    assign empty  = (occ_q == 2'd0);
    assign rd_vec = mem_q[rp_q];

endmodule

// File: rtl/layer_stream_serializer.sv
// Serializes a captured layer output vector into one word per beat,
// with double buffering, word-order selection and drop accounting.
module layer_stream_serializer
    import layer_stream_serializer_pkg::*;
#(
    parameter int  DATA_WIDTH = 16,
    parameter int  NUM_WORDS  = 30,
    parameter bit  MSB_FIRST  = 1'b0,
    parameter int  CNT_WIDTH  = 16,
    localparam int IDX_W      = idx_w(NUM_WORDS)
) (
    input  logic                            s_axi_aclk,
    input  logic                            s_axi_aresetn,
    input  logic                            in_valid,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic [IDX_W-1:0]                out_index,
    output logic                            busy,
    output logic                            overflow,
    output logic [CNT_WIDTH-1:0]            drop_count,
    input  logic                            clear_stats
);

    localparam int               VEC_W    = NUM_WORDS * DATA_WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    ser_state_e           state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     word_sel;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] drop_q, drop_d;

    logic             buf_full, buf_empty;
    logic [VEC_W-1:0] rd_vec;
    logic             accept, is_last, pop, capture, drop;

    assign accept  = out_valid & out_ready;
    assign is_last = (cnt_q == LAST_IDX);
    assign pop     = accept & is_last;
    // A buffer freed on this edge can take the incoming vector.
    assign capture = in_valid & (~buf_full | pop);
    assign drop    = in_valid & buf_full & ~pop;

    vector_pingpong_buf #(
        .VEC_W (VEC_W)
    ) u_buf (
        .clk    (s_axi_aclk),
        .rst_n  (s_axi_aresetn),
        .push   (capture),
        .pop    (pop),
        .wr_vec (in_data),
        .full   (buf_full),
        .empty  (buf_empty),
        .rd_vec (rd_vec)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (capture) state_d = ST_SEND;
            ST_SEND: if (pop && !buf_full && !capture) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = is_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + 1'b1;
        end
        if (clear_stats) begin
            overflow_d = 1'b0;
            drop_d     = '0;
        end
    end

    always_comb begin
        out_valid = (state_q == ST_SEND);
        out_index = cnt_q;
        out_last  = out_valid & is_last;
        word_sel  = MSB_FIRST ? (LAST_IDX - cnt_q) : cnt_q;
        out_data  = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (out_valid && (int'(word_sel) == i)) begin
                out_data = rd_vec[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign busy       = ~buf_empty;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_layer_stream_serializer.sv
// Randomized and directed bench for layer_stream_serializer against a
// queue-based vector model; two instances cover both word orders.
module tb_layer_stream_serializer;

    localparam int DW = 8;
    localparam int NW = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          in_valid;
    logic [31:0]   in_data;
    logic          out_ready;
    logic          clear_stats;

    logic [7:0]    l_data, m_data;
    logic          l_valid, m_valid;
    logic          l_last, m_last;
    logic [1:0]    l_index, m_index;
    logic          l_busy, m_busy;
    logic          l_ovf, m_ovf;
    logic [1:0]    l_drop, m_drop;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mq[$];
    int          mcnt;
    bit          movf;
    int          mdrop;

    always #5 clk = ~clk;

    layer_stream_serializer #(
        .DATA_WIDTH (DW), .NUM_WORDS (NW), .MSB_FIRST (1'b0), .CNT_WIDTH (CW)
    ) u_lsb (
        .s_axi_aclk (clk), .s_axi_aresetn (rstn),
        .in_valid (in_valid), .in_data (in_data),
        .out_data (l_data), .out_valid (l_valid), .out_ready (out_ready),
        .out_last (l_last), .out_index (l_index), .busy (l_busy),
        .overflow (l_ovf), .drop_count (l_drop), .clear_stats (clear_stats)
    );

    layer_stream_serializer #(
        .DATA_WIDTH (DW), .NUM_WORDS (NW), .MSB_FIRST (1'b1), .CNT_WIDTH (CW)
    ) u_msb (
        .s_axi_aclk (clk), .s_axi_aresetn (rstn),
        .in_valid (in_valid), .in_data (in_data),
        .out_data (m_data), .out_valid (m_valid), .out_ready (out_ready),
        .out_last (m_last), .out_index (m_index), .busy (m_busy),
        .overflow (m_ovf), .drop_count (m_drop), .clear_stats (clear_stats)
    );

    task automatic expect_eq(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] wd(input logic [31:0] v, input int k);
        return v[8*k +: 8];
    endfunction

    task automatic model_reset();
        mq.delete();
        mcnt  = 0;
        movf  = 1'b0;
        mdrop = 0;
    endtask

    task automatic model_edge(input bit v, input logic [31:0] d, input bit r,
                              input bit c, input bit rn);
        bit mv;
        bit done;
        int eff;
        if (!rn) begin
            model_reset();
            return;
        end
        mv   = (mq.size() > 0);
        done = mv && r && (mcnt == NW - 1);
        if (mv && r) mcnt = done ? 0 : mcnt + 1;
        eff = mq.size() - (done ? 1 : 0);
        if (done) void'(mq.pop_front());
        if (v) begin
            if (eff < 2) begin
                mq.push_back(d);
            end else begin
                movf = 1'b1;
                if (mdrop < (1 << CW) - 1) mdrop++;
            end
        end
        if (c) begin
            movf  = 1'b0;
            mdrop = 0;
        end
    endtask

    task automatic check_outs();
        bit mv;
        mv = (mq.size() > 0);
        expect_eq("valid", l_valid, mv);
        expect_eq("valid_msb", m_valid, mv);
        expect_eq("busy", l_busy, mv);
        expect_eq("busy_msb", m_busy, mv);
        expect_eq("overflow", l_ovf, movf);
        expect_eq("overflow_msb", m_ovf, movf);
        expect_eq("drop_count", l_drop, mdrop);
        expect_eq("drop_count_msb", m_drop, mdrop);
        expect_eq("index", l_index, mcnt);
        expect_eq("index_msb", m_index, mcnt);
        expect_eq("last", l_last, mv && (mcnt == NW - 1));
        expect_eq("last_msb", m_last, mv && (mcnt == NW - 1));
        if (mv) begin
            expect_eq("data", l_data, wd(mq[0], mcnt));
            expect_eq("data_msb", m_data, wd(mq[0], NW - 1 - mcnt));
        end
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit r,
                         input bit c, input bit rn);
        in_valid    = v;
        in_data     = d;
        out_ready   = r;
        clear_stats = c;
        rstn        = rn;
        check_outs();
        @(posedge clk);
        model_edge(v, d, r, c, rn);
        @(negedge clk);
    endtask

    task automatic check_reset_state();
        expect_eq("rst_valid", l_valid, 1'b0);
        expect_eq("rst_busy", l_busy, 1'b0);
        expect_eq("rst_data", l_data, 8'h00);
        expect_eq("rst_data_msb", m_data, 8'h00);
        expect_eq("rst_index", l_index, 2'd0);
        expect_eq("rst_last", l_last, 1'b0);
        expect_eq("rst_ovf", l_ovf, 1'b0);
        expect_eq("rst_drop", l_drop, 2'd0);
    endtask

    initial begin
        rstn        = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        clear_stats = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        model_reset();
        rstn = 1'b1;
        check_reset_state();

        // Basic vector, both orders.
        cycle(1, 32'h44332211, 1, 0, 1);
        expect_eq("first_word", l_data, 8'h11);
        expect_eq("first_word_msb", m_data, 8'h44);
        repeat (6) cycle(0, 0, 1, 0, 1);
        expect_eq("idle_busy", l_busy, 1'b0);

        // Stalled delivery with a 1,0,0,1 ready pattern.
        cycle(1, 32'hA1B2C3D4, 1, 0, 1);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, (i % 4 == 0) || (i % 4 == 3), 0, 1);
        end

        // Three vectors, two buffered and the third dropped.
        cycle(1, 32'h0D0C0B0A, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 32'h1D1C1B1A, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(1, 32'h2D2C2B2A, 0, 0, 1);
        expect_eq("drop_one", l_drop, 2'd1);
        expect_eq("ovf_one", l_ovf, 1'b1);
        repeat (10) cycle(0, 0, 1, 0, 1);

        // Saturation of the drop counter, then clear racing a drop.
        cycle(1, 32'h55555555, 0, 0, 1);
        cycle(1, 32'h66666666, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(1, 32'h77777777, 0, 0, 1);
        expect_eq("drop_sat", l_drop, 2'd3);
        cycle(1, 32'h88888888, 0, 1, 1);
        expect_eq("clr_ovf", l_ovf, 1'b0);
        expect_eq("clr_drop", l_drop, 2'd0);
        repeat (10) cycle(0, 0, 1, 0, 1);

        // Reset in the middle of a vector with another buffered.
        cycle(1, 32'h93929190, 1, 0, 1);
        cycle(1, 32'hA3A2A1A0, 1, 0, 1);
        cycle(0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 0);
        check_reset_state();
        cycle(0, 0, 1, 0, 1);
        cycle(1, 32'hC3C2C1C0, 1, 0, 1);
        expect_eq("restart_idx", l_index, 2'd0);
        expect_eq("restart_data", l_data, 8'hC0);
        repeat (6) cycle(0, 0, 1, 0, 1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 3) == 0), $urandom(),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 99) != 0));
        end
        repeat (12) cycle(0, 0, 1, 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/layer_stream_serializer.md
# layer_stream_serializer

Parametrised inter-layer serializer for the zyNet pipeline. It replaces the per-layer IDLE/SEND hold-and-shift logic between Layer_N and Layer_N+1. It captures the parallel vector a layer produces (NUM_WORDS × DATA_WIDTH), double-buffers it, and streams it one word per accepted beat over a valid/ready handshake with last/index sideband. It adds backpressure, word-order selection, gap-free back-to-back vectors and overflow accounting, none of which the current inline logic provides.

## Interface
- DATA_WIDTH, 16: width of one neuron output word (`dataWidth).
- NUM_WORDS, 30: words per vector (`numNeuronLayerN); ≥1.
- MSB_FIRST, 0: 0 = word 0 (bits DATA_WIDTH-1:0) sent first; 1 = highest word sent first.
- CNT_WIDTH, 16: width of the drop counter.
- IDX_W, localparam: max(1, $clog2(NUM_WORDS)).

Ports:
- s_axi_aclk  in  1  clock.
- s_axi_aresetn  in  1  reset, synchronous, active-low.
- in_valid  in  1  vector strobe (the upstream layer's o_valid[0]); one-cycle pulse.
- in_data  in  NUM_WORDS*DATA_WIDTH  parallel layer output, sampled when in_valid=1.
- out_data  out  DATA_WIDTH  current word.
- out_valid  out  1  word available.
- out_ready  in  1  downstream accepts; tie to 1 for current layers.
- out_last  out  1  current word is the final word of its vector.
- out_index  out  IDX_W  position of the current word in transmit order (0 … NUM_WORDS-1).
- busy  out  1  at least one buffer is occupied.
- overflow  out  1  sticky; set when a vector is dropped.
- drop_count  out  CNT_WIDTH  number of dropped vectors; saturating.
- clear_stats  in  1  synchronous clear of overflow and drop_count.

## Operation
- Two vector buffers (ping-pong): write pointer wp, read pointer rp, occupancy occ (0..2).
- Capture: when in_valid=1 and the effective occ is below 2, store in_data in buf[wp], flip wp and increment occ. The effective occ already accounts for a buffer released in the same cycle.
- Drop: when in_valid=1 and the effective occ is 2, discard the vector, set overflow, and increment drop_count (saturating at all-ones). Buffer contents are untouched.
- States: IDLE (occ=0, out_valid=0) and SEND (out_valid=1).
  - IDLE→SEND on capture.
  - SEND→IDLE when the last word is accepted and no other buffer is full and no capture occurs that cycle.
- Beat accepted when out_valid & out_ready. On acceptance the word counter advances. If the accepted beat carries out_last, buf[rp] is released (rp flips, occ decrements) and the counter returns to 0.
- out_data, out_index and out_last are held stable while out_valid=1 and out_ready=0.
- out_data is buf[rp] word k, where k = cnt if MSB_FIRST=0, else NUM_WORDS-1-cnt. out_index = cnt. out_last = (cnt == NUM_WORDS-1).
- NUM_WORDS=1: every beat has out_last=1.
- clear_stats=1 in the same cycle as a drop: clear wins; overflow=0 and drop_count=0.

## Timing
- Reset (s_axi_aresetn=0 at a clock edge): out_valid=0, out_last=0, out_index=0, out_data=0, busy=0, overflow=0, drop_count=0, occ=0, wp=rp=0, state IDLE. Buffer data is not reset.
- Reset mid-stream aborts the vector in flight; no further beats are produced.
- Latency: in_valid at edge t while idle → out_valid=1 with word 0 after edge t (visible in cycle t+1).
- Throughput: one word per cycle with out_ready=1. A vector takes exactly NUM_WORDS beats.
- Back-to-back: if buffer B is full when the last word of A is accepted at edge t, word 0 of B is presented after edge t. There is no bubble.
- busy and overflow update on the same edge as the capture, release or drop that changes them.

## Structure
- DATA_WIDTH and NUM_WORDS take their values from the shared include.v macros (`dataWidth, `numNeuronLayerN). The block itself adds no new globals.
- One sub-module, vector_pingpong_buf, holds the 2-entry buffer with wp, rp and occ and exposes push, pop, full, empty and rd_vec.
- Word select, counter, FSM and statistics stay in layer_stream_serializer.
- zyNet instantiates one serializer per layer boundary, with out_ready=1.

## Test plan
- Reset, then NUM_WORDS=4, DATA_WIDTH=8, in_data=0x44332211, in_valid pulse, out_ready=1 → beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles; index 0..3; out_last only on 0x44; then out_valid=0 and busy=0.
- Same stimulus with MSB_FIRST=1 → beats 0x44, 0x33, 0x22, 0x11.
- out_ready toggled 1,0,0,1,… → every beat delivered exactly once, with data, index and last stable during stalls.
- Three vectors pulsed 2 cycles apart with out_ready=0 → first two are buffered; the third is dropped (overflow=1, drop_count=1). After out_ready=1, 8 beats are delivered with no gap between the vectors.
- drop_count preset to max (CNT_WIDTH=2, four drops) → the counter saturates at 3. Pulse clear_stats → overflow=0, drop_count=0.
- Assert reset in the middle of vector 1 with vector 2 buffered → next cycle out_valid=0 and busy=0; a new vector afterwards starts cleanly at index 0.
